// File: rtl/hs32_fetch.sv
// hs32_fetch: program counter, single-outstanding memory fetch, 2-entry prefetch queue to decode
module hs32_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] addr,
   output logic        rd,
   input  logic [31:0] dtr,
   input  logic        valid,
   output logic [31:0] instd,
   output logic [31:0] pcd,
   output logic        ackd,
   input  logic        reqd,
   input  logic        flush,
   input  logic [31:0] newpc
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DROP = 2'd2;
   logic [1:0]  state, state_n, count, proj, tail;
   logic [31:0] req_pc, inst0, inst1, pc0, pc1;
   logic        wr, xfer;
   assign ackd    = (count != 2'd0) && !flush;
   assign xfer    = ackd && reqd;
   assign wr      = (state == WAIT) && valid && !flush;
   assign proj    = count + {1'b0, wr} - {1'b0, xfer};
   assign tail    = count - {1'b0, xfer};
   assign rd      = reset && !flush && (proj <= 2'd1) && ((state == IDLE) || ((state == WAIT) && valid));
   assign instd   = inst0;
   assign pcd     = pc0;
   // next state: a response ends WAIT unless the next request is issued; flush turns a pending response into a drop
   always_comb begin
      state_n = ((state == WAIT) && valid) ? (rd ? WAIT : IDLE) :
                ((state == WAIT) && flush) ? DROP :
                ((state == DROP) && valid) ? IDLE :
                ((state == IDLE) && rd)    ? WAIT : state;
   end
   // program counter, address of the outstanding request, and fetch state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         addr   <= RESET_PC;
         req_pc <= RESET_PC;
      end else begin
         state <= state_n;
         if (flush) addr <= {newpc[31:2], 2'b00};
         else if (rd) addr <= addr + 32'd4;
         if (rd) req_pc <= addr;
      end
   end
   // queue: pop shifts entry 1 to the head only when it holds data, so an emptied head keeps its last value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= 2'd0;
         inst0 <= 32'd0;
         inst1 <= 32'd0;
         pc0   <= 32'd0;
         pc1   <= 32'd0;
      end else begin
         count <= flush ? 2'd0 : proj;
         if (xfer && (count == 2'd2)) begin
            inst0 <= inst1;
            pc0   <= pc1;
         end
         if (wr && (tail == 2'd0)) begin
            inst0 <= dtr;
            pc0   <= req_pc;
         end
         if (wr && (tail != 2'd0)) begin
            inst1 <= dtr;
            pc1   <= req_pc;
         end
      end
   end
endmodule
